// File: rtl/palette_arb_pkg.sv
// Shared types and helpers for the palette lookup arbiter.
// Index and colour widths match the 8-bit to 12-bit RGB sprite palette ROM.
package palette_arb_pkg;

  localparam int PAL_IDX_W = 8;
  localparam int COLOR_W   = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb12_t;

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_prio_ptr, with wrap.
// An asserted override hands the grant straight to i_ovr_id.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_prio_ptr,
  input  logic            i_ovr_en,
  input  logic [ID_W-1:0] i_ovr_id,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_gnt_id,
  output logic            o_gnt_vld
);

  int unsigned w_idx;

  always_comb begin
    o_grant   = '0;
    o_gnt_id  = '0;
    o_gnt_vld = 1'b0;
    w_idx     = 0;
    if (i_ovr_en) begin
      o_grant[i_ovr_id] = 1'b1;
      o_gnt_id          = i_ovr_id;
      o_gnt_vld         = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        w_idx = 32'(i_prio_ptr) + k;
        if (w_idx >= N) w_idx = w_idx - N;
        if (!o_gnt_vld && i_req[ID_W'(w_idx)]) begin
          o_grant[ID_W'(w_idx)] = 1'b1;
          o_gnt_id              = ID_W'(w_idx);
          o_gnt_vld             = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Round-robin sharing of one palette ROM among sprite renderers, with bounded lock bursts.
// Grant in cycle N, pal_index in N+1, tagged colour response in N+2; no backpressure.
module palette_lookup_arbiter
  import palette_arb_pkg::*;
#(
  parameter int                   NUM_REQ         = 4,
  parameter int                   MAX_BURST       = 16,
  parameter logic [PAL_IDX_W-1:0] TRANSPARENT_IDX = 8'h00,
  parameter int                   ID_W            = $clog2(NUM_REQ)
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 lock,
  input  logic [NUM_REQ-1:0][PAL_IDX_W-1:0]  index,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [PAL_IDX_W-1:0]               pal_index,
  input  logic [COLOR_W-1:0]                 pal_red,
  input  logic [COLOR_W-1:0]                 pal_green,
  input  logic [COLOR_W-1:0]                 pal_blue,
  output logic                               rsp_valid,
  output logic [ID_W-1:0]                    rsp_id,
  output logic [COLOR_W-1:0]                 rsp_red,
  output logic [COLOR_W-1:0]                 rsp_green,
  output logic [COLOR_W-1:0]                 rsp_blue,
  output logic                               rsp_transparent
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [ID_W-1:0]      r_prio_ptr;
  logic [ID_W-1:0]      r_owner_q;
  logic                 r_locked_q;
  logic [CNT_W-1:0]     r_burst_cnt;
  logic                 r_issue_v;
  logic [ID_W-1:0]      r_id_q;
  logic [PAL_IDX_W-1:0] r_pal_index;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  rgb12_t               r_rsp_rgb;
  logic                 r_rsp_transparent;

  logic                 w_lock_live;
  logic [ID_W-1:0]      w_gnt_id;
  logic                 w_gnt_vld;

  // The lock only survives while the owner still requests, still asks, and has budget left.
  assign w_lock_live = r_locked_q && req[r_owner_q] && lock[r_owner_q]
                       && (r_burst_cnt < CNT_W'(MAX_BURST));

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .i_req      (req),
    .i_prio_ptr (r_prio_ptr),
    .i_ovr_en   (w_lock_live),
    .i_ovr_id   (r_owner_q),
    .o_grant    (grant),
    .o_gnt_id   (w_gnt_id),
    .o_gnt_vld  (w_gnt_vld)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_prio_ptr  <= '0;
      r_owner_q   <= '0;
      r_locked_q  <= 1'b0;
      r_burst_cnt <= '0;
    end else if (w_lock_live) begin
      r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end else begin
      if (r_locked_q) begin
        r_locked_q <= 1'b0;
        r_prio_ptr <= ID_W'(next_ptr(32'(r_owner_q), NUM_REQ));
      end
      // A fresh grant in the same cycle a lock ends takes precedence for the pointer.
      if (w_gnt_vld) begin
        r_owner_q   <= w_gnt_id;
        r_burst_cnt <= CNT_W'(1);
        r_locked_q  <= (MAX_BURST > 1) && lock[w_gnt_id];
        r_prio_ptr  <= ID_W'(next_ptr(32'(w_gnt_id), NUM_REQ));
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_issue_v         <= 1'b0;
      r_id_q            <= '0;
      r_pal_index       <= '0;
      r_rsp_valid       <= 1'b0;
      r_rsp_id          <= '0;
      r_rsp_rgb         <= '0;
      r_rsp_transparent <= 1'b0;
    end else begin
      r_issue_v <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_pal_index <= index[w_gnt_id];
        r_id_q      <= w_gnt_id;
      end
      r_rsp_valid <= r_issue_v;
      r_rsp_id    <= r_id_q;
      if (r_issue_v) begin
        r_rsp_rgb         <= '{red: pal_red, green: pal_green, blue: pal_blue};
        r_rsp_transparent <= (r_pal_index == TRANSPARENT_IDX);
      end
    end
  end

  assign pal_index       = r_pal_index;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_id;
  assign rsp_red         = r_rsp_rgb.red;
  assign rsp_green       = r_rsp_rgb.green;
  assign rsp_blue        = r_rsp_rgb.blue;
  assign rsp_transparent = r_rsp_transparent;

endmodule
